// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a single-word line.
// Hits return data combinationally; misses and all stores go to backing memory and stall the CPU until mem_ack.
module dcache #(
   parameter int SETS = 8,
   parameter int IDXW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        re,
   input  logic        we,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [15:0] miss_cnt
);

   localparam int TAGW = 30 - IDXW;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t            state;
   logic [SETS-1:0]   valid;
   logic [TAGW-1:0]   tag_arr  [SETS];
   logic [31:0]       data_arr [SETS];
   logic [31:0]       lat_addr;
   logic [31:0]       lat_wdata;

   logic [IDXW-1:0]   idx;
   logic [IDXW-1:0]   lat_idx;
   logic [TAGW-1:0]   atag;
   logic [TAGW-1:0]   lat_tag;
   logic              hit;
   logic              fill_done;
   logic              write_done;
   logic              unused_bits;

   assign idx         = addr[2+IDXW-1:2];
   assign atag        = addr[31:2+IDXW];
   assign lat_idx     = lat_addr[2+IDXW-1:2];
   assign lat_tag     = lat_addr[31:2+IDXW];
   assign unused_bits = ^addr[1:0];

   assign hit        = re & ~we & valid[idx] & (tag_arr[idx] == atag);
   assign fill_done  = (state == FILL)  & mem_ack;
   assign write_done = (state == WRITE) & mem_ack;

   // Outputs are forced quiet while rst is high, since the state register
   // only clears at the next edge.
   assign mem_req   = ~rst & (state != IDLE);
   assign mem_we    = ~rst & (state == WRITE);
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   always_comb begin
      stall = 1'b0;
      rdata = 32'd0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (we)
                  stall = 1'b1;
               else if (re) begin
                  if (hit) rdata = data_arr[idx];
                  else     stall = 1'b1;
               end
            end
            FILL: begin
               stall = ~mem_ack;
               if (mem_ack) rdata = mem_rdata;
            end
            WRITE:   stall = ~mem_ack;
            default: stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         valid     <= '0;
         miss_cnt  <= 16'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (we) begin
                  lat_addr  <= {addr[31:2], 2'b00};
                  lat_wdata <= wdata;
                  state     <= WRITE;
               end else if (re && !hit) begin
                  lat_addr <= {addr[31:2], 2'b00};
                  miss_cnt <= miss_cnt + 16'd1;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  valid[lat_idx] <= 1'b1;
                  state          <= IDLE;
               end
            end
            WRITE: begin
               if (mem_ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data arrays carry no reset; valid bits alone decide hits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_done) begin
            tag_arr[lat_idx]  <= lat_tag;
            data_arr[lat_idx] <= mem_rdata;
         end else if (write_done && valid[lat_idx] && (tag_arr[lat_idx] == lat_tag)) begin
            data_arr[lat_idx] <= lat_wdata;
         end
      end
   end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: drives CPU loads/stores, plays the backing memory, checks each cycle inline.
module tb_dcache;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        re;
   logic        we;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [15:0] miss_cnt;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_miss = 16'd0;

   always #5 clk = ~clk;

   dcache #(.SETS(8), .IDXW(3)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .re(re), .we(we),
      .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .miss_cnt(miss_cnt)
   );

   // Every driver task starts 1ns after a rising edge and ends 1ns after one.
   task automatic load_miss(input logic [31:0] a, input int nwait, input logic [31:0] d);
      int stall_cycles;
      addr = a; re = 1'b1; we = 1'b0; mem_ack = 1'b0;
      #1;
      stall_cycles = 0;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL miss_stall_idle @%h: got %b want 1", a, stall); end
      if (stall === 1'b1) stall_cycles++;
      exp_miss = exp_miss + 16'd1;
      @(posedge clk) #1;
      for (int i = 0; i < nwait; i++) begin
         checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {a[31:2], 2'b00} || stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_wait @%h: req=%b we=%b maddr=%h stall=%b want 1 0 %h 1", a, mem_req, mem_we, mem_addr, stall, {a[31:2], 2'b00});
         end
         if (stall === 1'b1) stall_cycles++;
         @(posedge clk) #1;
      end
      mem_ack = 1'b1; mem_rdata = d;
      #1;
      checks++;
      if (stall !== 1'b0 || rdata !== d) begin
         errors++; $display("FAIL fill_ack @%h: stall=%b rdata=%h want 0 %h", a, stall, rdata, d);
      end
      checks++;
      if (stall_cycles != nwait + 1) begin
         errors++; $display("FAIL miss_stall_len @%h: got %0d want %0d", a, stall_cycles, nwait + 1);
      end
      @(posedge clk) #1;
      mem_ack = 1'b0; re = 1'b0;
      checks++;
      if (miss_cnt !== exp_miss) begin errors++; $display("FAIL miss_cnt @%h: got %0d want %0d", a, miss_cnt, exp_miss); end
   endtask

   task automatic load_hit(input logic [31:0] a, input logic [31:0] exp);
      addr = a; re = 1'b1; we = 1'b0; mem_ack = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || rdata !== exp || mem_req !== 1'b0) begin
         errors++; $display("FAIL load_hit @%h: stall=%b rdata=%h req=%b want 0 %h 0", a, stall, rdata, mem_req, exp);
      end
      @(posedge clk) #1;
      re = 1'b0;
      checks++;
      if (miss_cnt !== exp_miss) begin errors++; $display("FAIL hit_miss_cnt @%h: got %0d want %0d", a, miss_cnt, exp_miss); end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] wd, input int nwait, input logic also_re);
      addr = a; wdata = wd; we = 1'b1; re = also_re; mem_ack = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL store_idle @%h: stall=%b req=%b want 1 0", a, stall, mem_req);
      end
      @(posedge clk) #1;
      for (int i = 0; i < nwait; i++) begin
         checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || mem_wdata !== wd || stall !== 1'b1) begin
            errors++;
            $display("FAIL write_wait @%h: req=%b we=%b maddr=%h mwdata=%h stall=%b want 1 1 %h %h 1", a, mem_req, mem_we, mem_addr, mem_wdata, stall, {a[31:2], 2'b00}, wd);
         end
         @(posedge clk) #1;
      end
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (stall !== 1'b0 || rdata !== 32'd0 || mem_we !== 1'b1) begin
         errors++; $display("FAIL write_ack @%h: stall=%b rdata=%h mem_we=%b want 0 0 1", a, stall, rdata, mem_we);
      end
      @(posedge clk) #1;
      mem_ack = 1'b0; we = 1'b0; re = 1'b0;
      checks++;
      if (miss_cnt !== exp_miss || mem_req !== 1'b0) begin
         errors++; $display("FAIL store_end @%h: miss_cnt=%0d req=%b want %0d 0", a, miss_cnt, mem_req, exp_miss);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; re = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'd0 || miss_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_outputs: stall=%b req=%b rdata=%h miss=%0d want 0 0 0 0", stall, mem_req, rdata, miss_cnt);
      end
      rst = 1'b0; re = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'd0) begin
         errors++; $display("FAIL idle_quiet: stall=%b req=%b rdata=%h want 0 0 0", stall, mem_req, rdata);
      end
      @(posedge clk) #1;
   endtask

   task automatic test_read_miss_hit();
      load_miss(32'h0000_0010, 2, 32'hDEAD_BEEF);
      load_hit(32'h0000_0010, 32'hDEAD_BEEF);
      load_hit(32'h0000_0013, 32'hDEAD_BEEF);
   endtask

   task automatic test_store_hit();
      store(32'h0000_0010, 32'h1234_5678, 2, 1'b0);
      load_hit(32'h0000_0010, 32'h1234_5678);
   endtask

   task automatic test_store_miss();
      store(32'h0000_0040, 32'hAAAA_0040, 1, 1'b0);
      load_miss(32'h0000_0040, 1, 32'hCAFE_0040);
      load_hit(32'h0000_0040, 32'hCAFE_0040);
   endtask

   task automatic test_conflict();
      load_miss(32'h0000_0030, 1, 32'h3030_3030);
      load_miss(32'h0000_0010, 0, 32'h1234_5678);
      load_hit(32'h0000_0010, 32'h1234_5678);
   endtask

   task automatic test_re_we_both();
      store(32'h0000_0020, 32'h2020_2020, 1, 1'b1);
      load_hit(32'h0000_0040, 32'hCAFE_0040);
   endtask

   task automatic test_ack_idle();
      re = 1'b0; we = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      #1;
      checks++;
      if (stall !== 1'b0 || rdata !== 32'd0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL ack_idle: stall=%b rdata=%h req=%b want 0 0 0", stall, rdata, mem_req);
      end
      @(posedge clk) #1;
      mem_ack = 1'b0;
      load_hit(32'h0000_0010, 32'h1234_5678);
   endtask

   task automatic test_back_to_back();
      load_miss(32'h0000_0064, 1, 32'h6464_6464);
      load_hit(32'h0000_0064, 32'h6464_6464);
      load_hit(32'h0000_0010, 32'h1234_5678);
      load_hit(32'h0000_0064, 32'h6464_6464);
   endtask

   task automatic test_reset_during_fill();
      addr = 32'h0000_0054; re = 1'b1; we = 1'b0; mem_ack = 1'b0;
      @(posedge clk) #1;
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL fill_started: req=%b want 1", mem_req); end
      rst = 1'b1; re = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0) begin
         errors++; $display("FAIL rst_gating: req=%b stall=%b rdata=%h want 0 0 0", mem_req, stall, rdata);
      end
      @(posedge clk) #1;
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0054;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0) begin
         errors++; $display("FAIL late_ack: req=%b stall=%b rdata=%h want 0 0 0", mem_req, stall, rdata);
      end
      @(posedge clk) #1;
      mem_ack = 1'b0;
      exp_miss = 16'd0;
      checks++;
      if (miss_cnt !== 16'd0) begin errors++; $display("FAIL rst_miss_cnt: got %0d want 0", miss_cnt); end
      load_miss(32'h0000_0054, 1, 32'h5454_0054);
      load_miss(32'h0000_0010, 1, 32'h1234_5678);
      load_hit(32'h0000_0054, 32'h5454_0054);
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_re_we_both();
      test_ack_idle();
      test_back_to_back();
      test_reset_during_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter SETS, default 8, number of direct-mapped lines (power of two, >=2).
REQ-002 SHALL have parameter IDXW, default 3, log2(SETS); tag width = 30-IDXW.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  32  CPU byte address; addr[1:0] ignored, word access only.
REQ-006 SHALL have port wdata  input  32  CPU store data.
REQ-007 SHALL have port re  input  1  CPU load request.
REQ-008 SHALL have port we  input  1  CPU store request.
REQ-009 SHALL have port rdata  output  32  load data to CPU result mux.
REQ-010 SHALL have port stall  output  1  CPU must hold PC and inputs while high.
REQ-011 SHALL have port mem_req  output  1  backing-memory request valid.
REQ-012 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-013 SHALL have port mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 SHALL have port mem_wdata  output  32  store data to memory.
REQ-015 SHALL have port mem_ack  input  1  one-cycle completion pulse from memory.
REQ-016 SHALL have port mem_rdata  input  32  read data, valid only with mem_ack.
REQ-017 SHALL have port miss_cnt  output  16  count of load misses.

Function
REQ-018 SHALL store per line: valid bit, tag (addr[31:2+IDXW]), 32-bit data; index = addr[2+IDXW-1:2].
REQ-019 SHALL define hit = re & ~we & valid[idx] & (tag[idx] == addr tag), combinational.
REQ-020 SHALL implement FSM states IDLE, FILL, WRITE.
REQ-021 In IDLE with hit: rdata = line data same cycle, stall = 0, no memory request, zero added latency.
REQ-022 In IDLE with re & ~we & ~hit: stall = 1 same cycle, latch word address, go to FILL, increment miss_cnt (16-bit wrap).
REQ-023 In IDLE with we (re ignored when both high): stall = 1 same cycle, latch address and wdata, go to WRITE.
REQ-024 In IDLE with re = we = 0: stall = 0, no state change.
REQ-025 mem_req SHALL be 1 exactly while state is FILL or WRITE; mem_we = 1 only in WRITE; mem_addr/mem_wdata SHALL be the latched values, stable until ack.
REQ-026 In FILL/WRITE, stall SHALL equal ~mem_ack; the ack cycle releases the CPU.
REQ-027 FILL on mem_ack: rdata = mem_rdata that cycle; line written valid with latched tag and mem_rdata; next state IDLE.
REQ-028 WRITE on mem_ack: if the line holds the latched tag and is valid, its data SHALL be updated to latched wdata; no allocation on store miss; next state IDLE.
REQ-029 Policy SHALL be write-through: memory always holds the latest stored word; no dirty state.
REQ-030 mem_ack while IDLE SHALL be ignored.
REQ-031 Read-miss latency SHALL be (cycles to mem_ack) with stall released in the ack cycle; a request following in the next cycle is evaluated in IDLE.
REQ-032 rdata SHALL be 0 when neither a hit nor a FILL ack is in progress.

Reset
REQ-033 On rst high at a clock edge: all valid bits = 0, state = IDLE, miss_cnt = 0, latched address/data = 0.
REQ-034 While rst high: mem_req = 0, stall = 0, rdata = 0.
REQ-035 Reset during FILL/WRITE SHALL abandon the access; a later mem_ack SHALL be ignored and no line written.
REQ-036 Tag/data arrays need not be reset; only valid bits gate hits.

Verification
REQ-037 After reset, load 0x0000_0010 with memory acking after 3 cycles with 0xDEAD_BEEF -> stall high 3 cycles, rdata = 0xDEAD_BEEF in ack cycle, miss_cnt = 1; repeat load -> stall 0, same rdata, miss_cnt stays 1.
REQ-038 Store 0x1234_5678 to cached 0x10 -> mem_req/mem_we high with mem_addr 0x10, mem_wdata 0x1234_5678 until ack; following load of 0x10 hits with 0x1234_5678.
REQ-039 Store to uncached 0x40, then load 0x40 -> store goes to memory, load misses (miss_cnt increments), no allocation on store.
REQ-040 Conflict: load 0x10 then 0x30 (SETS=8, same index 4) -> both miss; reload 0x10 misses again.
REQ-041 Assert rst during FILL, then pulse mem_ack next cycle -> state IDLE, mem_req 0, load of the same address misses again.
REQ-042 re and we both high to 0x20 -> handled as a store only, miss_cnt unchanged.
